galois_lfsr_checker: RTL and testbench

GALOIS_LFSR_CHECKER -- requirements
Module: galois_lfsr_checker

---
 rtl/galois_lfsr_pkg.sv | 18 +
 rtl/galois_err_counter.sv | 35 +++
 rtl/galois_lfsr_checker.sv | 125 ++++++++++++
 tb/tb_galois_lfsr_checker.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/galois_lfsr_pkg.sv
// Shared definitions for the 3-bit Galois LFSR checker: state encoding,
// word width and the fixed next-state polynomial.
package galois_lfsr_pkg;

  localparam int LFSR_W = 3;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // Period-7 sequence: 001,101,111,110,011,100,010,001
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {q[0], q[2], q[1] ^ q[0]};
  endfunction

endpackage

// File: rtl/galois_err_counter.sv
// Saturating error counter with synchronous clear; clear has priority
// over a coincident increment.
module galois_err_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/galois_lfsr_checker.sv
// Synchronises to an incoming 3-bit Galois LFSR stream (HUNT/VERIFY/LOCKED)
// and flags mismatches once locked, with a flywheel expected value.
module galois_lfsr_checker
  import galois_lfsr_pkg::*;
#(
  parameter int LOCK_MATCHES    = 3,
  parameter int LOSS_MISMATCHES = 2,
  parameter int CNT_W           = 8
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              in_valid,
  input  logic [LFSR_W-1:0] in_data,
  input  logic              clr_cnt,
  output logic              locked,
  output logic              err_pulse,
  output logic              lock_lost,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int MATCH_W = (LOCK_MATCHES < 2) ? 1 : $clog2(LOCK_MATCHES + 1);
  localparam int MISS_W  = (LOSS_MISMATCHES < 2) ? 1 : $clog2(LOSS_MISMATCHES + 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_MATCHES - 1);
  localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(LOSS_MISMATCHES - 1);

  state_e              state_q;
  logic [LFSR_W-1:0]   expected_q;
  logic [MATCH_W-1:0]  match_cnt_q;
  logic [MISS_W-1:0]   miss_cnt_q;
  logic                locked_q;
  logic                err_pulse_q;
  logic                lock_lost_q;

  logic [LFSR_W-1:0]   exp_adv_d;
  logic [LFSR_W-1:0]   seed_d;
  logic                hit_d;
  logic                err_d;

  assign exp_adv_d = lfsr_next(expected_q);
  assign seed_d    = lfsr_next(in_data);
  assign hit_d     = (in_data == expected_q);
  assign err_d     = in_valid && (state_q == LOCKED) && !hit_d;

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q     <= HUNT;
      expected_q  <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      err_pulse_q <= 1'b0;
      lock_lost_q <= 1'b0;
      if (in_valid) begin
        case (state_q)
          HUNT: begin
            // 000 is the LFSR lock-up value and can never seed a sequence
            if (in_data != '0) begin
              expected_q  <= seed_d;
              match_cnt_q <= '0;
              state_q     <= VERIFY;
            end
          end
          VERIFY: begin
            if (hit_d) begin
              expected_q <= exp_adv_d;
              if (match_cnt_q == MATCH_LAST) begin
                match_cnt_q <= '0;
                miss_cnt_q  <= '0;
                locked_q    <= 1'b1;
                state_q     <= LOCKED;
              end else begin
                match_cnt_q <= match_cnt_q + 1'b1;
              end
            end else if (in_data != '0) begin
              expected_q  <= seed_d;
              match_cnt_q <= '0;
            end else begin
              match_cnt_q <= '0;
              state_q     <= HUNT;
            end
          end
          LOCKED: begin
            // Flywheel: the received word never reseeds once locked
            expected_q <= exp_adv_d;
            if (hit_d) begin
              miss_cnt_q <= '0;
            end else begin
              err_pulse_q <= 1'b1;
              if (miss_cnt_q == MISS_LAST) begin
                miss_cnt_q  <= '0;
                locked_q    <= 1'b0;
                lock_lost_q <= 1'b1;
                state_q     <= HUNT;
              end else begin
                miss_cnt_q <= miss_cnt_q + 1'b1;
              end
            end
          end
          default: begin
            state_q  <= HUNT;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  galois_err_counter #(
    .CNT_W(CNT_W)
  ) u_err_counter (
    .clk   (clk),
    .rst_ni(arst_n),
    .clr_i (clr_cnt),
    .inc_i (err_d),
    .cnt_o (err_cnt)
  );

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_galois_lfsr_checker.sv
// Directed and randomized bench for galois_lfsr_checker against a
// sequence-table reference model.
module tb_galois_lfsr_checker;

  localparam int LM   = 3;
  localparam int LL   = 2;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [2:0]    in_data = 3'd0;
  logic          clr_cnt = 1'b0;
  logic          locked;
  logic          err_pulse;
  logic          lock_lost;
  logic [CW-1:0] err_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int seq [7] = '{1, 5, 7, 6, 3, 4, 2};
  int m_mode;   // 0 hunt, 1 verify, 2 locked
  int m_exp;
  int m_mcnt;
  int m_miss;
  int m_errcnt;
  int m_locked;
  int m_pulse;
  int m_lost;

  galois_lfsr_checker #(
    .LOCK_MATCHES   (LM),
    .LOSS_MISMATCHES(LL),
    .CNT_W          (CW)
  ) dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .clr_cnt  (clr_cnt),
    .locked   (locked),
    .err_pulse(err_pulse),
    .lock_lost(lock_lost),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  function automatic int nxt(input int x);
    for (int i = 0; i < 7; i++) begin
      if (seq[i] == x) return seq[(i + 1) % 7];
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_exp = 0; m_mcnt = 0; m_miss = 0;
    m_errcnt = 0; m_locked = 0; m_pulse = 0; m_lost = 0;
  endtask

  task automatic model_step(input int v, input int d, input int clr);
    m_pulse = 0;
    m_lost  = 0;
    if (v != 0) begin
      if (m_mode == 0) begin
        if (d != 0) begin
          m_exp = nxt(d); m_mcnt = 0; m_mode = 1;
        end
      end else if (m_mode == 1) begin
        if (d == m_exp) begin
          m_mcnt++;
          m_exp = nxt(m_exp);
          if (m_mcnt == LM) begin
            m_mode = 2; m_miss = 0; m_locked = 1;
          end
        end else if (d != 0) begin
          m_exp = nxt(d); m_mcnt = 0;
        end else begin
          m_mode = 0;
        end
      end else begin
        if (d != m_exp) begin
          m_pulse = 1;
          m_miss++;
          if (m_miss == LL) begin
            m_mode = 0; m_locked = 0; m_lost = 1; m_miss = 0;
          end
        end else begin
          m_miss = 0;
        end
        m_exp = nxt(m_exp);
      end
    end
    if (clr != 0) m_errcnt = 0;
    else if (m_pulse != 0 && m_errcnt < CMAX) m_errcnt++;
  endtask

  task automatic check(input string tag, input logic [7:0] got, input int exp);
    checks++;
    assert (got === 8'(exp)) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".locked"},    {7'd0, locked},    m_locked);
    check({tag, ".err_pulse"}, {7'd0, err_pulse}, m_pulse);
    check({tag, ".lock_lost"}, {7'd0, lock_lost}, m_lost);
    check({tag, ".err_cnt"},   {6'd0, err_cnt},   m_errcnt);
  endtask

  task automatic drive(input string tag, input int v, input int d, input int clr);
    @(negedge clk);
    in_valid = v[0];
    in_data  = d[2:0];
    clr_cnt  = clr[0];
    @(posedge clk);
    #1;
    model_step(v, d, clr);
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    arst_n   = 1'b0;
    in_valid = 1'b0;
    in_data  = 3'd0;
    clr_cnt  = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  task automatic clean_lock(input string tag);
    drive(tag, 1, 1, 0);
    drive(tag, 1, 5, 0);
    drive(tag, 1, 7, 0);
    drive(tag, 1, 6, 0);
  endtask

  initial begin
    int d;
    int v;
    int c;

    // Reset state
    do_reset("reset");

    // Clean lock, then a single error while locked
    clean_lock("lock");
    check("lock.locked_final", {7'd0, locked}, 1);
    drive("single_err", 1, 0, 0);
    check("single_err.pulse", {7'd0, err_pulse}, 1);
    drive("single_err_recover", 1, 4, 0);
    check("single_err.locked", {7'd0, locked}, 1);
    check("single_err.cnt", {6'd0, err_cnt}, 1);

    // Lock loss after two consecutive misses
    do_reset("reset2");
    clean_lock("lock2");
    drive("loss1", 1, 2, 0);
    drive("loss2", 1, 2, 0);
    check("loss.lost", {7'd0, lock_lost}, 1);
    check("loss.locked", {7'd0, locked}, 0);
    drive("loss.after", 1, 0, 0);

    // Reseed inside VERIFY
    do_reset("reset3");
    drive("reseed", 1, 1, 0);
    drive("reseed", 1, 7, 0);
    drive("reseed", 1, 6, 0);
    drive("reseed", 1, 3, 0);
    check("reseed.not_yet", {7'd0, locked}, 0);
    drive("reseed", 1, 4, 0);
    check("reseed.locked", {7'd0, locked}, 1);

    // Saturation, then clear colliding with an error
    do_reset("reset4");
    clean_lock("lock4");
    for (int i = 0; i < 5; i++) begin
      drive("sat_err", 1, 0, 0);
      drive("sat_ok", 1, m_exp, 0);
    end
    check("sat.cnt", {6'd0, err_cnt}, CMAX);
    drive("clr_with_err", 1, 0, 1);
    check("clr.cnt", {6'd0, err_cnt}, 0);
    check("clr.pulse", {7'd0, err_pulse}, 1);

    // Gaps during VERIFY, then reset while locked
    do_reset("reset5");
    drive("gap", 1, 1, 0);
    drive("gap", 0, 5, 0);
    drive("gap", 1, 5, 0);
    drive("gap", 0, 0, 0);
    drive("gap", 0, 3, 0);
    drive("gap", 1, 7, 0);
    drive("gap", 0, 6, 0);
    check("gap.not_yet", {7'd0, locked}, 0);
    drive("gap", 1, 6, 0);
    check("gap.locked", {7'd0, locked}, 1);
    do_reset("reset_locked");
    check("reset_locked.lost", {7'd0, lock_lost}, 0);

    // Randomized stream against the model
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0) ? 1 : 0;
      c = ($urandom_range(0, 19) == 0) ? 1 : 0;
      if (m_mode == 0) d = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 7);
      else d = ($urandom_range(0, 9) < 8) ? m_exp : $urandom_range(0, 7);
      drive("rand", v, d, c);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
